// File: rtl/pu_cfg_pkg.sv
// Shared constants, state types and helpers for the protection-unit config slave.
// Policy layout: bit 2+2i grants writes to master ID i, bit 3+2i grants reads.
package pu_cfg_pkg;

  localparam logic [15:0] OFF_SCRATCH = 16'h0000;
  localparam logic [15:0] OFF_POLICY  = 16'h0040;
  localparam logic [31:0] UNIT_STRIDE = 32'h0001_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  function automatic int unsigned wr_bit(input int unsigned i);
    return 2 + 2 * i;
  endfunction

  function automatic int unsigned rd_bit(input int unsigned i);
    return 3 + 2 * i;
  endfunction

  function automatic logic [31:0] policy_mask(input int unsigned num_ids);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < num_ids; i++) begin
      m = m | (32'h1 << wr_bit(i)) | (32'h1 << rd_bit(i));
    end
    return m;
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/pu_cfg_regbank.sv
// One protection unit's SCRATCH and POLICY storage with byte-strobed writes.
// POLICY keeps only the per-ID permission bits; everything else reads as zero.
module pu_cfg_regbank
  import pu_cfg_pkg::*;
#(
  parameter int          NUM_IDS    = 2,
  parameter logic [31:0] POLICY_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_scratch,
  input  logic        we_policy,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] scratch_o,
  output logic [31:0] policy_o,
  output logic        policy_upd_o
);

  localparam logic [31:0] MASK = policy_mask(NUM_IDS);

  logic [31:0] scratch_q, scratch_d;
  logic [31:0] policy_q, policy_d;
  logic        upd_q, upd_d;

  always_comb begin
    scratch_d = scratch_q;
    policy_d  = policy_q;
    if (we_scratch) scratch_d = strb_merge(scratch_q, wdata, wstrb);
    if (we_policy)  policy_d  = strb_merge(policy_q, wdata, wstrb) & MASK;
    // The update pulse is tied to the low byte lane, where the permission bits live.
    upd_d = we_policy & wstrb[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scratch_q <= '0;
      policy_q  <= POLICY_RST & MASK;
      upd_q     <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      policy_q  <= policy_d;
      upd_q     <= upd_d;
    end
  end

  assign scratch_o    = scratch_q;
  assign policy_o     = policy_q;
  assign policy_upd_o = upd_q;

endmodule

// File: rtl/pu_axil_cfg_slave.sv
// AXI4-Lite config slave serving NUM_UNITS protection units, one 64 KiB window each.
// Valid/ready: a beat transfers on a rising edge where both are high; valid holds until then.
module pu_axil_cfg_slave
  import pu_cfg_pkg::*;
#(
  parameter int          ADDR_W     = 17,
  parameter int          NUM_UNITS  = 2,
  parameter int          NUM_IDS    = 2,
  parameter logic [31:0] POLICY_RST = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_W-1:0]       s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [NUM_UNITS*32-1:0] policy_o,
  output logic [NUM_UNITS-1:0]    policy_upd_o
);

  localparam logic [31:0] MAP_END = 32'(NUM_UNITS) * UNIT_STRIDE;

  function automatic logic [15:0] off_of(input logic [ADDR_W-1:0] a);
    return {a[15:2], 2'b00};
  endfunction

  function automatic logic [31:0] unit_of(input logic [ADDR_W-1:0] a);
    return 32'(a) >> 16;
  endfunction

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < MAP_END) && (off_of(a) == OFF_SCRATCH || off_of(a) == OFF_POLICY);
  endfunction

  w_state_e          w_state_q, w_state_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;

  r_state_e          r_state_q, r_state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic              aw_hs, w_hs, ar_hs, commit, w_ok, r_ok;
  logic [ADDR_W-1:0] eff_addr;
  logic [31:0]       eff_data;
  logic [3:0]        eff_strb;
  logic [15:0]       w_off, r_off;
  logic [31:0]       w_unit, r_unit, rd_val;

  logic [NUM_UNITS-1:0] we_scratch, we_policy;
  logic [31:0]          unit_scratch [NUM_UNITS];
  logic [31:0]          unit_policy  [NUM_UNITS];

  // Write path: a beat accepted this cycle is forwarded straight to the commit.
  always_comb begin
    aw_hs    = s_axi_awvalid & awready_q;
    w_hs     = s_axi_wvalid & wready_q;
    eff_addr = aw_held_q ? awaddr_q : s_axi_awaddr;
    eff_data = w_held_q ? wdata_q : s_axi_wdata;
    eff_strb = w_held_q ? wstrb_q : s_axi_wstrb;
    w_ok     = addr_ok(eff_addr);
    w_off    = off_of(eff_addr);
    w_unit   = unit_of(eff_addr);
    commit   = (w_state_q == W_IDLE) && (aw_held_q | aw_hs) && (w_held_q | w_hs);

    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axi_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end

    case (w_state_q)
      W_IDLE: begin
        if (commit) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = w_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  // Read path: data is sampled at the AR handshake, before any same-edge write lands.
  always_comb begin
    ar_hs  = s_axi_arvalid & arready_q;
    r_ok   = addr_ok(s_axi_araddr);
    r_off  = off_of(s_axi_araddr);
    r_unit = unit_of(s_axi_araddr);
    rd_val = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (r_ok && r_unit == 32'(u)) begin
        rd_val = (r_off == OFF_POLICY) ? unit_policy[u] : unit_scratch[u];
      end
    end

    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rdata_d   = rd_val;
          rresp_d   = r_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    assign we_scratch[u] = commit && w_ok && (w_unit == 32'(u)) && (w_off == OFF_SCRATCH);
    assign we_policy[u]  = commit && w_ok && (w_unit == 32'(u)) && (w_off == OFF_POLICY);

    pu_cfg_regbank #(
      .NUM_IDS    (NUM_IDS),
      .POLICY_RST (POLICY_RST)
    ) u_bank (
      .clk          (clk),
      .rst          (rst),
      .we_scratch   (we_scratch[u]),
      .we_policy    (we_policy[u]),
      .wstrb        (eff_strb),
      .wdata        (eff_data),
      .scratch_o    (unit_scratch[u]),
      .policy_o     (unit_policy[u]),
      .policy_upd_o (policy_upd_o[u])
    );

    assign policy_o[32*u +: 32] = unit_policy[u];
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_pu_axil_cfg_slave.sv
// Bench for pu_axil_cfg_slave: directed register-map cases plus randomized traffic
// checked against an array model of the unit register map.
module tb_pu_axil_cfg_slave;

  localparam int AW = 18;
  localparam int NU = 2;
  localparam logic [31:0] PMASK = 32'h0000_003C;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [AW-1:0]   s_axi_awaddr = '0;
  logic            s_axi_awvalid = 1'b0;
  logic            s_axi_awready;
  logic [31:0]     s_axi_wdata = '0;
  logic [3:0]      s_axi_wstrb = '0;
  logic            s_axi_wvalid = 1'b0;
  logic            s_axi_wready;
  logic [1:0]      s_axi_bresp;
  logic            s_axi_bvalid;
  logic            s_axi_bready = 1'b0;
  logic [AW-1:0]   s_axi_araddr = '0;
  logic            s_axi_arvalid = 1'b0;
  logic            s_axi_arready;
  logic [31:0]     s_axi_rdata;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rvalid;
  logic            s_axi_rready = 1'b0;
  logic [NU*32-1:0] policy_o;
  logic [NU-1:0]    policy_upd_o;

  pu_axil_cfg_slave #(
    .ADDR_W     (AW),
    .NUM_UNITS  (NU),
    .NUM_IDS    (2),
    .POLICY_RST (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .policy_o      (policy_o),
    .policy_upd_o  (policy_upd_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard and reference model
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_scratch [NU];
  logic [31:0] m_policy  [NU];
  int          m_upd     [NU];
  int          seen_upd  [NU];

  initial for (int u = 0; u < NU; u++) seen_upd[u] = 0;

  always @(posedge clk) begin
    if (!rst) for (int u = 0; u < NU; u++) if (policy_upd_o[u]) seen_upd[u]++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic m_ok(input logic [AW-1:0] a);
    logic [15:0] off;
    off = a[15:0] & 16'hFFFC;
    return ((a >> 16) < NU) && (off == 16'h0000 || off == 16'h0040);
  endfunction

  function automatic int m_unit(input logic [AW-1:0] a);
    return int'(a >> 16);
  endfunction

  function automatic logic m_is_pol(input logic [AW-1:0] a);
    return (a[15:0] & 16'hFFFC) == 16'h0040;
  endfunction

  function automatic logic [31:0] m_read(input logic [AW-1:0] a);
    if (!m_ok(a)) return 32'h0;
    return m_is_pol(a) ? m_policy[m_unit(a)] : m_scratch[m_unit(a)];
  endfunction

  function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_policy_vec();
    return {m_policy[1], m_policy[0]};
  endfunction

  task automatic model_reset();
    for (int u = 0; u < NU; u++) begin
      m_scratch[u] = 32'h0;
      m_policy[u]  = 32'h0;
    end
  endtask

  // Returns the expected policy_upd_o vector for this write.
  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] upd);
    upd = 2'b00;
    if (m_ok(a)) begin
      if (m_is_pol(a)) begin
        m_policy[m_unit(a)] = bytes_merge(m_policy[m_unit(a)], d, s) & PMASK;
        if (s[0]) begin
          upd[m_unit(a)] = 1'b1;
          m_upd[m_unit(a)]++;
        end
      end else begin
        m_scratch[m_unit(a)] = bytes_merge(m_scratch[m_unit(a)], d, s);
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit w_first, input int gap, input int bdelay);
    bit aw_done, w_done, hs_aw, hs_w;
    logic [1:0] exp_upd;
    logic [1:0] exp_resp;
    aw_done = 0;
    w_done  = 0;
    s_axi_awaddr = a;
    s_axi_wdata  = d;
    s_axi_wstrb  = s;
    for (int t = 0; t < 40 && !(aw_done && w_done); t++) begin
      s_axi_awvalid = !aw_done && (w_first ? (t >= gap) : 1'b1);
      s_axi_wvalid  = !w_done && (w_first ? 1'b1 : (t >= gap));
      hs_aw = s_axi_awvalid && s_axi_awready;
      hs_w  = s_axi_wvalid && s_axi_wready;
      check_eq("bvalid_early", s_axi_bvalid, 1'b0);
      tick();
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done  = 1;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check_eq("write_handshake", {aw_done, w_done}, 2'b11);
    exp_resp = m_ok(a) ? 2'b00 : 2'b10;
    model_write(a, d, s, exp_upd);
    check_eq("bvalid", s_axi_bvalid, 1'b1);
    check_eq("bresp", s_axi_bresp, exp_resp);
    check_eq("policy_o", policy_o, m_policy_vec());
    check_eq("policy_upd", policy_upd_o, exp_upd);
    for (int i = 0; i < bdelay; i++) begin
      tick();
      check_eq("bvalid_hold", s_axi_bvalid, 1'b1);
      check_eq("bresp_hold", s_axi_bresp, exp_resp);
      check_eq("upd_pulse_width", policy_upd_o, 2'b00);
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check_eq("bvalid_clear", s_axi_bvalid, 1'b0);
    check_eq("upd_after_b", policy_upd_o, 2'b00);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input int rdelay, output logic [31:0] data);
    bit done, hs;
    logic [31:0] exp_d;
    done = 0;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      hs = s_axi_arvalid && s_axi_arready;
      tick();
      if (hs) done = 1;
    end
    s_axi_arvalid = 1'b0;
    check_eq("read_handshake", done, 1'b1);
    exp_d = m_read(a);
    data  = s_axi_rdata;
    check_eq("rvalid", s_axi_rvalid, 1'b1);
    check_eq("rdata", s_axi_rdata, exp_d);
    check_eq("rresp", s_axi_rresp, m_ok(a) ? 2'b00 : 2'b10);
    for (int i = 0; i < rdelay; i++) begin
      tick();
      check_eq("rvalid_hold", s_axi_rvalid, 1'b1);
      check_eq("rdata_hold", s_axi_rdata, exp_d);
    end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    check_eq("rvalid_clear", s_axi_rvalid, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_rready  = 1'b0;
    tick();
    tick();
    check_eq("rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    check_eq("rst_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
    check_eq("rst_resp_data", {s_axi_bresp, s_axi_rresp, s_axi_rdata}, 36'h0);
    check_eq("rst_upd", policy_upd_o, 2'b00);
    model_reset();
    rst = 1'b0;
    tick();
  endtask

  logic [AW-1:0] addr_tbl [8];
  logic [31:0]   rd;
  logic [1:0]    upd_v;
  logic [31:0]   pre_val;

  initial begin
    for (int u = 0; u < NU; u++) m_upd[u] = 0;
    addr_tbl[0] = 18'h00000; addr_tbl[1] = 18'h00040; addr_tbl[2] = 18'h10000;
    addr_tbl[3] = 18'h10040; addr_tbl[4] = 18'h20040; addr_tbl[5] = 18'h00044;
    addr_tbl[6] = 18'h30000; addr_tbl[7] = 18'h10020;
    do_reset();

    // reset contents
    axi_read(18'h00040, 0, rd);
    axi_read(18'h10040, 1, rd);
    check_eq("policy_after_reset", policy_o, 64'h0);

    // basic read/write and policy encoding
    axi_write(18'h00000, 32'hF0F0F0F0, 4'hF, 0, 0, 0);
    axi_read(18'h00000, 0, rd);
    check_eq("scratch_full", rd, 32'hF0F0F0F0);
    axi_write(18'h00040, 32'h0000002C, 4'hF, 0, 0, 1);
    check_eq("policy_u0", policy_o[31:0], 32'h2C);
    axi_write(18'h10040, 32'h00000038, 4'hF, 1, 0, 0);
    check_eq("policy_u1", policy_o[63:32], 32'h38);
    axi_write(18'h00040, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_read(18'h00040, 0, rd);
    check_eq("policy_masked", rd, 32'h3C);
    axi_write(18'h00000, 32'hAABBCCDD, 4'b0010, 0, 0, 0);
    axi_read(18'h00000, 2, rd);
    check_eq("scratch_byte1", rd, 32'hF0F0CCF0);
    axi_write(18'h00040, 32'h00000000, 4'b0010, 0, 0, 0);

    // channel ordering and response back-pressure
    axi_write(18'h10000, 32'h12345678, 4'hF, 1, 3, 5);
    axi_write(18'h10003, 32'h9ABCDEF0, 4'hF, 0, 3, 5);
    axi_read(18'h10000, 0, rd);
    check_eq("scratch_u1_order", rd, 32'h9ABCDEF0);

    // unmapped accesses
    axi_read(18'h20040, 0, rd);
    axi_write(18'h00044, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(18'h30040, 32'hFFFFFFFF, 4'hF, 0, 1, 0);
    check_eq("policy_unmapped", policy_o, 64'h0000_0038_0000_003C);

    // same-edge write commit and read of the same register
    pre_val = m_read(18'h00000);
    s_axi_awaddr = 18'h00000; s_axi_wdata = 32'h11223344; s_axi_wstrb = 4'hF;
    s_axi_araddr = 18'h00000;
    check_eq("idle_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    check_eq("race_rvalid", s_axi_rvalid, 1'b1);
    check_eq("race_bvalid", s_axi_bvalid, 1'b1);
    check_eq("race_rdata_old", s_axi_rdata, pre_val);
    model_write(18'h00000, 32'h11223344, 4'hF, upd_v);
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    tick();
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    axi_read(18'h00000, 0, rd);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      a = addr_tbl[$urandom_range(0, 7)] | AW'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(a, $urandom_range(0, 3), rd);
    end
    check_eq("upd_count_u0", seen_upd[0], m_upd[0]);
    check_eq("upd_count_u1", seen_upd[1], m_upd[1]);

    // reset while a read response is pending
    axi_write(18'h10000, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    s_axi_araddr = 18'h10000;
    s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    check_eq("pending_rvalid", s_axi_rvalid, 1'b1);
    rst = 1'b1;
    tick();
    check_eq("rvalid_dropped", s_axi_rvalid, 1'b0);
    check_eq("policy_reset", policy_o, 64'h0);
    rst = 1'b0;
    model_reset();
    tick();
    check_eq("rvalid_no_replay", s_axi_rvalid, 1'b0);
    axi_read(18'h10000, 0, rd);
    axi_read(18'h00000, 0, rd);
    axi_read(18'h10040, 0, rd);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
